// File: rtl/rf_wr_arbiter_pkg.sv
// Shared CPU constants used by the register-file write arbiter and its neighbours.
package rf_wr_arbiter_pkg;

    localparam int CPU_REGNO_WIDTH = 5;
    localparam int CPU_REG_WIDTH   = 32;

endpackage

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter: writeback has absolute priority, the aux unit
// takes free slots and asks the CU for a pipeline stall once starved long enough.
module rf_wr_arbiter
    import rf_wr_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       i_core_stall,
    input  logic [CPU_REGNO_WIDTH-1:0] i_wb_rd_no,
    input  logic [CPU_REG_WIDTH-1:0]   i_wb_rd_val,
    input  logic                       i_aux_valid,
    input  logic [CPU_REGNO_WIDTH-1:0] i_aux_rd_no,
    input  logic [CPU_REG_WIDTH-1:0]   i_aux_rd_val,
    output logic                       o_aux_ready,
    output logic                       o_rf_wr_en,
    output logic [CPU_REGNO_WIDTH-1:0] o_rf_rd_no,
    output logic [CPU_REG_WIDTH-1:0]   o_rf_rd_val,
    output logic                       o_stall_req
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2
    } arb_state_t;

    localparam logic [3:0]                 STARVE_MAX_C = 4'(STARVE_MAX);
    localparam logic [CPU_REGNO_WIDTH-1:0] REG_ZERO     = {CPU_REGNO_WIDTH{1'b0}};

    logic                       wb_new_r;
    arb_state_t                 state_r;
    logic [3:0]                 starve_cnt_r;
    logic                       wb_need_s;
    logic                       aux_ready_s;
    logic                       aux_blocked_s;
    logic                       wr_en_s;
    logic [CPU_REGNO_WIDTH-1:0] wr_rd_s;
    logic [CPU_REG_WIDTH-1:0]   wr_val_s;

    // Grant decision; aux is held off while in reset so nothing is acknowledged then.
    always_comb begin
        wb_need_s     = wb_new_r && (i_wb_rd_no != REG_ZERO);
        aux_ready_s   = nrst && i_aux_valid && !wb_need_s;
        aux_blocked_s = i_aux_valid && !aux_ready_s;
    end

    assign o_aux_ready = aux_ready_s;

    // Select the write source for the next edge; register 0 is never written.
    always_comb begin
        wr_en_s  = 1'b0;
        wr_rd_s  = i_wb_rd_no;
        wr_val_s = i_wb_rd_val;
        if (wb_need_s) begin
            wr_en_s = 1'b1;
        end else if (aux_ready_s) begin
            wr_en_s  = (i_aux_rd_no != REG_ZERO);
            wr_rd_s  = i_aux_rd_no;
            wr_val_s = i_aux_rd_val;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Registered write port; index and data hold when no write happens.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            wb_new_r    <= 1'b0;
            o_rf_wr_en  <= 1'b0;
            o_rf_rd_no  <= REG_ZERO;
            o_rf_rd_val <= {CPU_REG_WIDTH{1'b0}};
        end else begin
            wb_new_r   <= !i_core_stall;
            o_rf_wr_en <= wr_en_s;
            if (wr_en_s) begin
                o_rf_rd_no  <= wr_rd_s;
                o_rf_rd_val <= wr_val_s;
            end
        end
    end

    // Starvation FSM; leaving on !aux_blocked covers both transfer and withdrawal.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_r      <= ST_IDLE;
            starve_cnt_r <= 4'd0;
            o_stall_req  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (aux_blocked_s) begin
                        state_r      <= ST_WAIT;
                        starve_cnt_r <= 4'd1;
                    end else begin
                        state_r      <= ST_IDLE;
                        starve_cnt_r <= 4'd0;
                    end
                    o_stall_req <= 1'b0;
                end
                ST_WAIT: begin
                    if (!aux_blocked_s) begin
                        state_r      <= ST_IDLE;
                        starve_cnt_r <= 4'd0;
                        o_stall_req  <= 1'b0;
                    end else if (starve_cnt_r >= STARVE_MAX_C) begin
                        state_r     <= ST_FORCE;
                        o_stall_req <= 1'b1;
                    end else begin
                        starve_cnt_r <= starve_cnt_r + 4'd1;
                        o_stall_req  <= 1'b0;
                    end
                end
                ST_FORCE: begin
                    if (!aux_blocked_s) begin
                        state_r      <= ST_IDLE;
                        starve_cnt_r <= 4'd0;
                        o_stall_req  <= 1'b0;
                    end else begin
                        o_stall_req <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    starve_cnt_r <= 4'd0;
                    o_stall_req  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Scoreboard bench for rf_wr_arbiter: each cycle pushes the expected register-file
// write, and the result is popped and compared after the following edge.
module tb_rf_wr_arbiter;
    import rf_wr_arbiter_pkg::*;

    logic                       clk = 1'b0;
    logic                       nrst = 1'b0;
    logic                       i_core_stall = 1'b0;
    logic [CPU_REGNO_WIDTH-1:0] i_wb_rd_no = 5'd0;
    logic [CPU_REG_WIDTH-1:0]   i_wb_rd_val = 32'd0;
    logic                       i_aux_valid = 1'b0;
    logic [CPU_REGNO_WIDTH-1:0] i_aux_rd_no = 5'd0;
    logic [CPU_REG_WIDTH-1:0]   i_aux_rd_val = 32'd0;
    logic                       o_aux_ready;
    logic                       o_rf_wr_en;
    logic [CPU_REGNO_WIDTH-1:0] o_rf_rd_no;
    logic [CPU_REG_WIDTH-1:0]   o_rf_rd_val;
    logic                       o_stall_req;

    typedef struct packed {
        logic        en;
        logic        chk;
        logic [4:0]  rd;
        logic [31:0] val;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         e;
    logic [4:0]  last_rd;
    logic [31:0] last_val;
    int          errors = 0;
    int          checks = 0;

    rf_wr_arbiter #(.STARVE_MAX(4)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .i_core_stall (i_core_stall),
        .i_wb_rd_no   (i_wb_rd_no),
        .i_wb_rd_val  (i_wb_rd_val),
        .i_aux_valid  (i_aux_valid),
        .i_aux_rd_no  (i_aux_rd_no),
        .i_aux_rd_val (i_aux_rd_val),
        .o_aux_ready  (o_aux_ready),
        .o_rf_wr_en   (o_rf_wr_en),
        .o_rf_rd_no   (o_rf_rd_no),
        .o_rf_rd_val  (o_rf_rd_val),
        .o_stall_req  (o_stall_req)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic stall, input logic [4:0] wrd, input logic [31:0] wval,
                         input logic av, input logic [4:0] ard, input logic [31:0] aval);
        i_core_stall = stall;
        i_wb_rd_no   = wrd;
        i_wb_rd_val  = wval;
        i_aux_valid  = av;
        i_aux_rd_no  = ard;
        i_aux_rd_val = aval;
        #1;
    endtask

    // Queue the expected write; a non-write expects the held index/data.
    task automatic push_exp(input logic en, input logic chk, input logic [4:0] rd, input logic [31:0] val);
        wr_t w;
        w.en  = en;
        w.chk = chk;
        w.rd  = en ? rd : last_rd;
        w.val = en ? val : last_val;
        if (en) begin
            last_rd  = rd;
            last_val = val;
        end
        exp_q.push_back(w);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        drive(1'b0, 5'd4, 32'h4444_4444, 1'b1, 5'd9, 32'h9999_9999);
        checks++;
        if (o_aux_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_aux_ready: got %0b want 0", o_aux_ready);
        end
        tick();
        tick();
        checks++;
        if ({o_rf_wr_en, o_rf_rd_no, o_rf_rd_val, o_stall_req} !== 39'd0) begin
            errors++;
            $display("FAIL reset_outputs: got en=%0b rd=%0d val=%h stall=%0b want all 0",
                     o_rf_wr_en, o_rf_rd_no, o_rf_rd_val, o_stall_req);
        end
        last_rd  = 5'd0;
        last_val = 32'd0;
        nrst = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checks++;
        if (o_aux_ready !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_aux_ready: got %0b want 0", o_aux_ready);
        end
        push_exp(1'b0, 1'b1, 5'd0, 32'd0);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (o_rf_wr_en !== e.en || o_rf_rd_no !== e.rd || o_rf_rd_val !== e.val) begin
            errors++;
            $display("FAIL post_reset_write: got en=%0b rd=%0d val=%h want en=%0b rd=%0d val=%h",
                     o_rf_wr_en, o_rf_rd_no, o_rf_rd_val, e.en, e.rd, e.val);
        end
    endtask

    // Writeback writes on the next edge; rd=0 is no write and data holds.
    task automatic test_wb();
        logic [4:0]  rd;
        logic [31:0] val;
        for (int i = 0; i < 3; i++) begin
            rd  = (i == 0) ? 5'd5 : ((i == 1) ? 5'd0 : 5'd12);
            val = (i == 0) ? 32'hDEAD_BEEF : ((i == 1) ? 32'h1111_1111 : 32'hA5A5_0F0F);
            drive(1'b0, rd, val, 1'b0, 5'd0, 32'd0);
            push_exp(rd != 5'd0, 1'b1, rd, val);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (o_rf_wr_en !== e.en || o_rf_rd_no !== e.rd || o_rf_rd_val !== e.val) begin
                errors++;
                $display("FAIL wb_write[%0d]: got en=%0b rd=%0d val=%h want en=%0b rd=%0d val=%h",
                         i, o_rf_wr_en, o_rf_rd_no, o_rf_rd_val, e.en, e.rd, e.val);
            end
        end
    endtask

    // Aux write when writeback is idle, including an accepted rd=0 request.
    task automatic test_aux();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b1, (i == 0) ? 5'd7 : 5'd0, (i == 0) ? 32'h1234_5678 : 32'hFFFF_0000);
            checks++;
            if (o_aux_ready !== 1'b1) begin
                errors++;
                $display("FAIL aux_ready[%0d]: got %0b want 1", i, o_aux_ready);
            end
            push_exp(i == 0, i == 0, 5'd7, 32'h1234_5678);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (o_rf_wr_en !== e.en || (e.chk && (o_rf_rd_no !== e.rd || o_rf_rd_val !== e.val)) || o_stall_req !== 1'b0) begin
                errors++;
                $display("FAIL aux_write[%0d]: got en=%0b rd=%0d val=%h stall=%0b want en=%0b rd=%0d val=%h stall=0",
                         i, o_rf_wr_en, o_rf_rd_no, o_rf_rd_val, o_stall_req, e.en, e.rd, e.val);
            end
        end
    endtask

    // Starvation: five blocked cycles reach FORCE, a core stall then lets aux through.
    task automatic test_starve();
        logic stall_s, ready_exp, sreq_exp;
        for (int k = 1; k <= 8; k++) begin
            stall_s   = (k >= 7);
            ready_exp = (k == 8);
            sreq_exp  = (k >= 5) && (k <= 7);
            drive(stall_s, (k == 8) ? 5'd21 : 5'(10 + k), 32'(k), 1'b1, 5'd9, 32'h0000_0099);
            checks++;
            if (o_aux_ready !== ready_exp) begin
                errors++;
                $display("FAIL starve_ready[%0d]: got %0b want %0b", k, o_aux_ready, ready_exp);
            end
            if (ready_exp) push_exp(1'b1, 1'b1, 5'd9, 32'h0000_0099);
            else push_exp(1'b1, 1'b1, 5'(10 + k), 32'(k));
            tick();
            e = exp_q.pop_front();
            checks++;
            if (o_rf_wr_en !== e.en || o_rf_rd_no !== e.rd || o_rf_rd_val !== e.val || o_stall_req !== sreq_exp) begin
                errors++;
                $display("FAIL starve_cycle[%0d]: got en=%0b rd=%0d val=%h stall=%0b want en=%0b rd=%0d val=%h stall=%0b",
                         k, o_rf_wr_en, o_rf_rd_no, o_rf_rd_val, o_stall_req, e.en, e.rd, e.val, sreq_exp);
            end
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        push_exp(1'b0, 1'b1, 5'd0, 32'd0);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (o_rf_wr_en !== e.en || o_rf_rd_no !== e.rd || o_rf_rd_val !== e.val || o_stall_req !== 1'b0) begin
            errors++;
            $display("FAIL starve_release: got en=%0b rd=%0d val=%h stall=%0b want en=0 rd=%0d val=%h stall=0",
                     o_rf_wr_en, o_rf_rd_no, o_rf_rd_val, o_stall_req, e.rd, e.val);
        end
    endtask

    // Stalled core holding wb rd=3: r3 once, then aux gets every stalled slot.
    task automatic test_core_stall();
        int          granted = 0;
        int          r3_writes = 0;
        logic        ready_exp;
        logic [4:0]  ard;
        logic [31:0] aval;
        for (int k = 1; k <= 6; k++) begin
            ard       = 5'(16 + granted);
            aval      = 32'h0000_0111 * 32'(granted + 1);
            ready_exp = (k != 1);
            drive(1'b1, 5'd3, 32'h0000_0033, 1'b1, ard, aval);
            checks++;
            if (o_aux_ready !== ready_exp) begin
                errors++;
                $display("FAIL cstall_ready[%0d]: got %0b want %0b", k, o_aux_ready, ready_exp);
            end
            if (ready_exp) begin
                push_exp(1'b1, 1'b1, ard, aval);
                granted++;
            end else begin
                push_exp(1'b1, 1'b1, 5'd3, 32'h0000_0033);
            end
            tick();
            if (o_rf_wr_en === 1'b1 && o_rf_rd_no === 5'd3) r3_writes++;
            e = exp_q.pop_front();
            checks++;
            if (o_rf_wr_en !== e.en || o_rf_rd_no !== e.rd || o_rf_rd_val !== e.val) begin
                errors++;
                $display("FAIL cstall_write[%0d]: got en=%0b rd=%0d val=%h want en=%0b rd=%0d val=%h",
                         k, o_rf_wr_en, o_rf_rd_no, o_rf_rd_val, e.en, e.rd, e.val);
            end
        end
        checks++;
        if (r3_writes != 1) begin
            errors++;
            $display("FAIL cstall_r3_once: got %0d writes want 1", r3_writes);
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        push_exp(1'b0, 1'b1, 5'd0, 32'd0);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (o_rf_wr_en !== e.en || o_rf_rd_no !== e.rd || o_rf_rd_val !== e.val) begin
            errors++;
            $display("FAIL cstall_idle: got en=%0b rd=%0d val=%h want en=0 rd=%0d val=%h",
                     o_rf_wr_en, o_rf_rd_no, o_rf_rd_val, e.rd, e.val);
        end
    endtask

    // Withdrawal clears the starve count: FORCE needs five fresh blocked cycles.
    task automatic test_withdraw();
        logic av, sreq_exp;
        for (int k = 1; k <= 9; k++) begin
            av       = (k != 4);
            sreq_exp = (k == 9);
            drive(1'b0, 5'd2, 32'(100 + k), av, 5'd6, 32'h0000_0066);
            checks++;
            if (o_aux_ready !== 1'b0) begin
                errors++;
                $display("FAIL wd_ready[%0d]: got %0b want 0", k, o_aux_ready);
            end
            push_exp(1'b1, 1'b1, 5'd2, 32'(100 + k));
            tick();
            e = exp_q.pop_front();
            checks++;
            if (o_rf_wr_en !== e.en || o_rf_rd_no !== e.rd || o_rf_rd_val !== e.val || o_stall_req !== sreq_exp) begin
                errors++;
                $display("FAIL wd_cycle[%0d]: got en=%0b rd=%0d val=%h stall=%0b want en=%0b rd=%0d val=%h stall=%0b",
                         k, o_rf_wr_en, o_rf_rd_no, o_rf_rd_val, o_stall_req, e.en, e.rd, e.val, sreq_exp);
            end
        end
    endtask

    // Reset while in FORCE: outputs clear, no aux write, aux re-presented afterwards.
    task automatic test_reset_force();
        nrst = 1'b0;
        drive(1'b0, 5'd2, 32'h0000_0202, 1'b1, 5'd6, 32'h0000_0066);
        checks++;
        if (o_stall_req !== 1'b1 || o_aux_ready !== 1'b0) begin
            errors++;
            $display("FAIL rf_pre: got stall=%0b ready=%0b want stall=1 ready=0", o_stall_req, o_aux_ready);
        end
        tick();
        checks++;
        if ({o_rf_wr_en, o_rf_rd_no, o_rf_rd_val, o_stall_req} !== 39'd0) begin
            errors++;
            $display("FAIL rf_outputs: got en=%0b rd=%0d val=%h stall=%0b want all 0",
                     o_rf_wr_en, o_rf_rd_no, o_rf_rd_val, o_stall_req);
        end
        last_rd  = 5'd0;
        last_val = 32'd0;
        nrst = 1'b1;
        drive(1'b0, 5'd2, 32'h0000_0202, 1'b1, 5'd6, 32'h0000_0066);
        checks++;
        if (o_aux_ready !== 1'b1) begin
            errors++;
            $display("FAIL rf_represent_ready: got %0b want 1", o_aux_ready);
        end
        push_exp(1'b1, 1'b1, 5'd6, 32'h0000_0066);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (o_rf_wr_en !== e.en || o_rf_rd_no !== e.rd || o_rf_rd_val !== e.val || o_stall_req !== 1'b0) begin
            errors++;
            $display("FAIL rf_represent_write: got en=%0b rd=%0d val=%h stall=%0b want en=1 rd=%0d val=%h stall=0",
                     o_rf_wr_en, o_rf_rd_no, o_rf_rd_val, o_stall_req, e.rd, e.val);
        end
    endtask

    initial begin
        last_rd  = 5'd0;
        last_val = 32'd0;
        test_reset();
        test_wb();
        test_aux();
        test_starve();
        test_core_stall();
        test_withdraw();
        test_reset_force();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
